// File: rtl/gen_edge_pkg.sv
// Shared defaults and constants for the generic edge detector family.
`timescale 1ns/1ps
package gen_edge_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 1;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;

  // Value every synchronizer and history flop takes in reset
  localparam logic SYNC_RST_VAL = 1'b0;

  // True when a requested synchronizer depth is within the supported range
  function automatic bit sync_stages_legal(input int unsigned stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage : gen_edge_pkg

// File: rtl/gen_sync_chain.sv
// Multi-bit flop-chain synchronizer for asynchronous level inputs.
`timescale 1ns/1ps
module gen_sync_chain
  import gen_edge_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift the sampled input down the chain; reset wipes every stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= {WIDTH{SYNC_RST_VAL}};
      end
    end else begin
      stage_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule : gen_sync_chain

// File: rtl/gen_pos_edge_detect.sv
// Per-bit synchronized rising-edge detector.
// Optional falling-edge output enabled by defining GPED_FALL_EDGE_EN.
`timescale 1ns/1ps
module gen_pos_edge_detect
  import gen_edge_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_edge
`ifdef GPED_FALL_EDGE_EN
  ,
  output logic [WIDTH-1:0] sig_fall
`endif
);

  // Reject unsupported synchronizer depths at elaboration
  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("gen_pos_edge_detect: SYNC_STAGES must be within 2..4");
  end

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hist_q;

  gen_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig),
    .sync_out (sync_q)
  );

  // Previous synchronized value for transition decoding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= {WIDTH{SYNC_RST_VAL}};
    end else begin
      hist_q <= sync_q;
    end
  end

  // Decoded purely from flop outputs, so no path from sig to the outputs
  assign sig_edge = sync_q & ~hist_q;

`ifdef GPED_FALL_EDGE_EN
  assign sig_fall = hist_q & ~sync_q;
`endif

endmodule : gen_pos_edge_detect

// File: tb/tb_gen_pos_edge_detect.sv
// Scoreboard bench for gen_pos_edge_detect: three configurations share stimulus.
`timescale 1ns/1ps
module tb_gen_pos_edge_detect;

  localparam int MAXC = 8192;

  logic       tb_clk = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] sig    = 4'b0000;

  logic       edge_d;
  logic [3:0] edge_w;
  logic [3:0] edge_s;
`ifdef GPED_FALL_EDGE_EN
  logic       fall_d;
  logic [3:0] fall_w;
  logic [3:0] fall_s;
`endif

  int errors = 0;
  int checks = 0;

  always #2.5 tb_clk = ~tb_clk;

  gen_pos_edge_detect u_dut_d (
    .clk      (tb_clk),
    .rst      (rst),
    .sig      (sig[0]),
    .sig_edge (edge_d)
`ifdef GPED_FALL_EDGE_EN
    ,
    .sig_fall (fall_d)
`endif
  );

  gen_pos_edge_detect #(.WIDTH(4), .SYNC_STAGES(2)) u_dut_w (
    .clk      (tb_clk),
    .rst      (rst),
    .sig      (sig),
    .sig_edge (edge_w)
`ifdef GPED_FALL_EDGE_EN
    ,
    .sig_fall (fall_w)
`endif
  );

  gen_pos_edge_detect #(.WIDTH(4), .SYNC_STAGES(3)) u_dut_s (
    .clk      (tb_clk),
    .rst      (rst),
    .sig      (sig),
    .sig_edge (edge_s)
`ifdef GPED_FALL_EDGE_EN
    ,
    .sig_fall (fall_s)
`endif
  );

  // Reference: what sig looked like at every rising edge, and whether reset was held there
  logic [3:0] sig_h [MAXC];
  bit         rst_h [MAXC];
  int         n_edges = 0;

  typedef struct {
    logic [3:0] e2;
    logic [3:0] f2;
    logic [3:0] e3;
    logic [3:0] f3;
  } exp_t;

  exp_t sb_q[$];

  // Value seen d flops deep after edge k: sig from d-1 edges earlier,
  // unless reset was present at any edge since then (which wipes it)
  function automatic logic [3:0] delayed(input int k, input int d);
    int j;
    j = k - d + 1;
    if (j < 0) return 4'b0000;
    for (int m = j; m <= k; m++) begin
      if (rst_h[m]) return 4'b0000;
    end
    return sig_h[j];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Stimulus-side recorder: log inputs at each edge and queue the expected response
  always @(posedge tb_clk) begin
    exp_t e;
    sig_h[n_edges] = sig;
    rst_h[n_edges] = rst;
    e.e2 = delayed(n_edges, 2) & ~delayed(n_edges, 3);
    e.f2 = delayed(n_edges, 3) & ~delayed(n_edges, 2);
    e.e3 = delayed(n_edges, 3) & ~delayed(n_edges, 4);
    e.f3 = delayed(n_edges, 4) & ~delayed(n_edges, 3);
    sb_q.push_back(e);
    n_edges++;
  end

  // Monitor: sample all DUT outputs 2 ns after each edge and compare to the queue
  always @(posedge tb_clk) begin
    exp_t e;
    #2;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 4'b0001, 4'b0000);
    end else begin
      e = sb_q.pop_front();
      check("edge_d", {3'b000, edge_d}, {3'b000, e.e2[0]});
      check("edge_w", edge_w, e.e2);
      check("edge_s", edge_s, e.e3);
`ifdef GPED_FALL_EDGE_EN
      check("fall_d", {3'b000, fall_d}, {3'b000, e.f2[0]});
      check("fall_w", fall_w, e.f2);
      check("fall_s", fall_s, e.f3);
`endif
    end
  end

  task automatic sample();
    @(posedge tb_clk);
    #2;
  endtask

  initial begin
    // Reset for one cycle with sig low
    rst = 1'b1;
    sig = 4'b0000;
    @(negedge tb_clk);
    #0.1;
    check("rst_edge_d", {3'b000, edge_d}, 4'b0000);
    check("rst_edge_w", edge_w, 4'b0000);
    @(negedge tb_clk);
    rst = 1'b0;

    // Rising edge on bit 0: latency 2 for SYNC_STAGES=2, 3 for SYNC_STAGES=3
    @(negedge tb_clk);
    sig = 4'b0001;
    sample(); check("rise_d_e1", {3'b000, edge_d}, 4'b0000); check("rise_s_e1", edge_s, 4'b0000);
    sample(); check("rise_d_e2", {3'b000, edge_d}, 4'b0001); check("rise_s_e2", edge_s, 4'b0000);
    sample(); check("rise_d_e3", {3'b000, edge_d}, 4'b0000); check("rise_s_e3", edge_s, 4'b0001);
    sample(); check("rise_s_e4", edge_s, 4'b0000);

    // Held high: no further pulses
    for (int i = 0; i < 4; i++) begin
      sample();
      check("hold_d", {3'b000, edge_d}, 4'b0000);
    end

    // Falling transition never pulses sig_edge
    @(negedge tb_clk);
    sig = 4'b0000;
    sample(); check("fall_d_e1", {3'b000, edge_d}, 4'b0000);
`ifdef GPED_FALL_EDGE_EN
    check("fallp_d_e1", {3'b000, fall_d}, 4'b0000);
`endif
    sample(); check("fall_d_e2", {3'b000, edge_d}, 4'b0000);
`ifdef GPED_FALL_EDGE_EN
    check("fallp_d_e2", {3'b000, fall_d}, 4'b0001);
`endif

    // Reset with sig high: release counts as a rising edge
    @(negedge tb_clk);
    rst = 1'b1;
    sig = 4'b0001;
    sample(); check("rsthi_d_in", {3'b000, edge_d}, 4'b0000);
    @(negedge tb_clk);
    rst = 1'b0;
    sample(); check("rsthi_d_e1", {3'b000, edge_d}, 4'b0000);
    sample(); check("rsthi_d_e2", {3'b000, edge_d}, 4'b0001);
    sample(); check("rsthi_d_e3", {3'b000, edge_d}, 4'b0000);

    // Multi-bit: 0000 -> 1010
    @(negedge tb_clk);
    sig = 4'b0000;
    repeat (5) @(negedge tb_clk);
    sig = 4'b1010;
    sample(); check("wide_e1", edge_w, 4'b0000);
    sample(); check("wide_e2", edge_w, 4'b1010);
    sample(); check("wide_e3", edge_w, 4'b0000);

    // Randomized phase with long-ish levels, short glitches and occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(negedge tb_clk);
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
      end else if (rst && $urandom_range(0, 1) == 0) begin
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        sig = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) begin
        logic [3:0] g;
        g = 4'($urandom);
        #0.5 sig = sig ^ g;
        #1.0 sig = sig ^ g;
      end
    end

    @(negedge tb_clk);
    rst = 1'b0;
    sig = 4'b0000;
    repeat (8) @(negedge tb_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gen_pos_edge_detect
